// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e : FSM state encoding (IDLE/REQ/WAIT/DONE)
//   SZ_B..SZ_D  : legal access size masks
//   align_mask  : size mask -> low address bits that must be zero for alignment
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [7:0] SZ_B = 8'h01;
    localparam logic [7:0] SZ_H = 8'h03;
    localparam logic [7:0] SZ_W = 8'h0F;
    localparam logic [7:0] SZ_D = 8'hFF;

    function automatic logic [2:0] align_mask(input logic [7:0] bytes);
        logic [2:0] m;
        case (bytes)
            SZ_B:    m = 3'd0;
            SZ_H:    m = 3'd1;
            SZ_W:    m = 3'd3;
            default: m = 3'd7;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane shifter for the load/store unit.
// Ports:
//   wr_bytes, wr_off, wr_data -> wr_strb, wr_lane_data : store path, shift left into lanes
//   rd_bytes, rd_off, rd_raw  -> rd_data               : load path, shift right and mask to size
// Lanes shifted past byte 7 are dropped on stores and read back as zero on loads.
module lsu_align #(
    parameter int DATA_W = 64
) (
    input  logic [7:0]        wr_bytes,
    input  logic [2:0]        wr_off,
    input  logic [DATA_W-1:0] wr_data,
    output logic [7:0]        wr_strb,
    output logic [DATA_W-1:0] wr_lane_data,
    input  logic [7:0]        rd_bytes,
    input  logic [2:0]        rd_off,
    input  logic [DATA_W-1:0] rd_raw,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] byte_mask;

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < 8; i++) begin
            byte_mask[8*i +: 8] = {8{rd_bytes[i]}};
        end
        // 8-bit context truncates strobes that spill past lane 7
        wr_strb      = wr_bytes << wr_off;
        wr_lane_data = wr_data << {wr_off, 3'b000};
        rd_data      = (rd_raw >> {rd_off, 3'b000}) & byte_mask;
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and a doubleword memory bus.
// Runs one bus transaction per memory instruction and stalls the core until it retires.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   acs_en/wr/bytes/addr/wdata      : access request from execute (held while stall)
//   acs_rdata                       : right-justified load data, valid in DONE
//   stall                           : freeze PC and register-file write
//   misalign                        : one-cycle misaligned-access flag (DONE only)
//   mem_req/we/addr/wstrb/wdata     : bus request side
//   mem_gnt, mem_rvalid, mem_rdata  : bus accept and response
// Build option: LSU_MISALIGN_CHK_EN enables the misalignment check; when undefined,
// misaligned accesses are issued and truncated at the doubleword boundary.
//
// state | meaning
// IDLE  | waiting for acs_en; latches the request
// REQ   | mem_req high, fields held until mem_gnt
// WAIT  | waiting for mem_rvalid; load data captured
// DONE  | stall released for one retire cycle, then IDLE
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acs_en,
    input  logic              acs_wr,
    input  logic [7:0]        acs_bytes,
    input  logic [ADDR_W-1:0] acs_addr,
    input  logic [DATA_W-1:0] acs_wdata,
    output logic [DATA_W-1:0] acs_rdata,
    output logic              stall,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_REQ  = 2'(ST_REQ);
    localparam logic [1:0] S_WAIT = 2'(ST_WAIT);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

    logic [1:0]        state;
    logic [2:0]        off_q;
    logic [7:0]        bytes_q;
    logic [7:0]        strb_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [DATA_W-1:0] rd_data;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .wr_bytes     (acs_bytes),
        .wr_off       (acs_addr[2:0]),
        .wr_data      (acs_wdata),
        .wr_strb      (strb_nxt),
        .wr_lane_data (wdata_nxt),
        .rd_bytes     (bytes_q),
        .rd_off       (off_q),
        .rd_raw       (mem_rdata),
        .rd_data      (rd_data)
    );

    assign mem_req = (state == S_REQ);
    assign stall   = acs_en & (state != S_DONE);

`ifdef LSU_MISALIGN_CHK_EN
    logic mis_det;
    logic mis_q;
    assign mis_det  = (acs_addr[2:0] & align_mask(acs_bytes)) != 3'b000;
    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            off_q     <= '0;
            bytes_q   <= '0;
            acs_rdata <= '0;
`ifdef LSU_MISALIGN_CHK_EN
            mis_q     <= 1'b0;
`endif
        end else begin
`ifdef LSU_MISALIGN_CHK_EN
            mis_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (acs_en) begin
`ifdef LSU_MISALIGN_CHK_EN
                        // Misaligned: no bus traffic, straight to the retire cycle
                        if (mis_det) begin
                            state     <= S_DONE;
                            acs_rdata <= '0;
                            mis_q     <= 1'b1;
                        end else
`endif
                        begin
                            state     <= S_REQ;
                            mem_we    <= acs_wr;
                            mem_addr  <= {acs_addr[ADDR_W-1:3], 3'b000};
                            mem_wstrb <= strb_nxt;
                            mem_wdata <= wdata_nxt;
                            off_q     <= acs_addr[2:0];
                            bytes_q   <= acs_bytes;
                            acs_rdata <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        acs_rdata <= mem_we ? '0 : rd_data;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu. Bus responses are driven by a small
// handshake helper with programmable grant and response delays.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        acs_en;
    logic        acs_wr;
    logic [7:0]  acs_bytes;
    logic [63:0] acs_addr;
    logic [63:0] acs_wdata;
    logic [63:0] acs_rdata;
    logic        stall;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    int          r_stall;
    int          r_req;
    int          r_first_req;
    int          r_mis;
    logic        r_stable;
    logic        r_done;
    logic [63:0] r_rd;
    logic [63:0] r_addr;
    logic        r_we;
    logic [7:0]  r_strb;
    logic [63:0] r_wdata;

    lsu #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .acs_en     (acs_en),
        .acs_wr     (acs_wr),
        .acs_bytes  (acs_bytes),
        .acs_addr   (acs_addr),
        .acs_wdata  (acs_wdata),
        .acs_rdata  (acs_rdata),
        .stall      (stall),
        .misalign   (misalign),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1 of the cycle in which execute presents the request.
    // Returns at posedge+1 of the cycle after DONE.
    task automatic txn(input logic wr, input logic [7:0] bytes, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rdata,
                       input int gnt_dly, input int rv_dly, input logic keep_en);
        int gnt_cyc;
        acs_en      = 1'b1;
        acs_wr      = wr;
        acs_bytes   = bytes;
        acs_addr    = addr;
        acs_wdata   = wdata;
        mem_rdata   = rdata;
        r_stall     = 0;
        r_req       = 0;
        r_first_req = -1;
        r_mis       = 0;
        r_stable    = 1'b1;
        r_done      = 1'b0;
        r_rd        = '0;
        gnt_cyc     = -1;
        for (int c = 0; c < 40; c++) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            #1;
            if (stall) r_stall++;
            if (misalign) r_mis++;
            if (mem_req) begin
                if (r_req == 0) begin
                    r_first_req = c;
                    r_addr      = mem_addr;
                    r_we        = mem_we;
                    r_strb      = mem_wstrb;
                    r_wdata     = mem_wdata;
                end else if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !==
                             {r_addr, r_we, r_strb, r_wdata}) begin
                    r_stable = 1'b0;
                end
                r_req++;
                if (r_req > gnt_dly) begin
                    mem_gnt = 1'b1;
                    gnt_cyc = c;
                end
            end
            if (gnt_cyc >= 0 && c == gnt_cyc + rv_dly) mem_rvalid = 1'b1;
            if (!stall) begin
                r_done = 1'b1;
                r_rd   = acs_rdata;
                break;
            end
            next_cycle();
        end
        next_cycle();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!keep_en || !r_done) acs_en = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        acs_en     = 1'b0;
        acs_wr     = 1'b0;
        acs_bytes  = 8'h00;
        acs_addr   = '0;
        acs_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) next_cycle();
        #1;
        chk("rst_mem_req",   64'(mem_req),   64'd0);
        chk("rst_mem_we",    64'(mem_we),    64'd0);
        chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_mem_addr",  mem_addr,       64'd0);
        chk("rst_mem_wdata", mem_wdata,      64'd0);
        chk("rst_acs_rdata", acs_rdata,      64'd0);
        chk("rst_misalign",  64'(misalign),  64'd0);
        chk("rst_stall",     64'(stall),     64'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Load double, aligned, minimum latency
        txn(1'b0, 8'hFF, 64'h8000_0008, 64'h0, 64'h1122_3344_5566_7788, 0, 1, 1'b0);
        chk("ld_d_done",  64'(r_done),  64'd1);
        chk("ld_d_addr",  r_addr,       64'h8000_0008);
        chk("ld_d_we",    64'(r_we),    64'd0);
        chk("ld_d_stall", 64'(r_stall), 64'd3);
        chk("ld_d_req",   64'(r_req),   64'd1);
        chk("ld_d_rdata", r_rd,         64'h1122_3344_5566_7788);

        // Non-memory instruction never stalls
        #1;
        chk("nomem_stall", 64'(stall), 64'd0);
        next_cycle();

        // Store byte lane 5; read data on the ack must be ignored
        txn(1'b1, 8'h01, 64'h8000_0005, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1'b0);
        chk("st_b_done",  64'(r_done),  64'd1);
        chk("st_b_strb",  64'(r_strb),  64'h20);
        chk("st_b_wdata", r_wdata,      64'h0000_AB00_0000_0000);
        chk("st_b_we",    64'(r_we),    64'd1);
        chk("st_b_addr",  r_addr,       64'h8000_0000);
        chk("st_b_rdata", r_rd,         64'd0);
        chk("st_b_stall", 64'(r_stall), 64'd3);

        // Load half lane 6 with 3-cycle grant delay
        txn(1'b0, 8'h03, 64'h8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 3, 1, 1'b0);
        chk("ld_h_req",    64'(r_req),    64'd4);
        chk("ld_h_stable", 64'(r_stable), 64'd1);
        chk("ld_h_rdata",  r_rd,          64'hBEEF);
        chk("ld_h_stall",  64'(r_stall),  64'd6);
        chk("ld_h_strb",   64'(r_strb),   64'hC0);

        // Size masking on loads
        txn(1'b0, 8'h0F, 64'h0000_1004, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, 1, 1'b0);
        chk("ld_w_rdata", r_rd, 64'hDEAD_BEEF);
        txn(1'b0, 8'h01, 64'h0000_1001, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1, 1'b0);
        chk("ld_b_rdata", r_rd, 64'hCD);
        txn(1'b0, 8'h03, 64'h0000_1000, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1, 1'b0);
        chk("ld_h0_rdata", r_rd, 64'hCDEF);

`ifdef LSU_MISALIGN_CHK_EN
        // Misaligned word store: no bus traffic, one-cycle flag
        txn(1'b1, 8'h0F, 64'h8000_0006, 64'h1122_3344, 64'h0, 0, 1, 1'b0);
        chk("mis_done",  64'(r_done),  64'd1);
        chk("mis_req",   64'(r_req),   64'd0);
        chk("mis_flag",  64'(r_mis),   64'd1);
        chk("mis_stall", 64'(r_stall), 64'd1);
        chk("mis_rdata", r_rd,         64'd0);
        #1;
        chk("mis_after", 64'(misalign), 64'd0);
        next_cycle();
`else
        // Misaligned word store without the check: truncated at the doubleword edge
        txn(1'b1, 8'h0F, 64'h8000_0006, 64'h1122_3344, 64'h0, 0, 2, 1'b0);
        chk("trunc_st_strb",  64'(r_strb),  64'hC0);
        chk("trunc_st_wdata", r_wdata,      64'h3344_0000_0000_0000);
        chk("trunc_st_stall", 64'(r_stall), 64'd4);
        chk("trunc_st_mis",   64'(r_mis),   64'd0);
        txn(1'b0, 8'h0F, 64'h8000_0006, 64'h0, 64'hAABB_CCDD_EEFF_0011, 0, 1, 1'b0);
        chk("trunc_ld_rdata", r_rd, 64'hAABB);
`endif

        // Reset during WAIT, stale response afterwards
        acs_en    = 1'b1;
        acs_wr    = 1'b0;
        acs_bytes = 8'hFF;
        acs_addr  = 64'h0000_2000;
        mem_rdata = 64'h5555_6666_7777_8888;
        next_cycle();
        mem_gnt = 1'b1;
        #1;
        chk("rw_req_in_req", 64'(mem_req), 64'd1);
        next_cycle();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        #1;
        chk("rw_req_in_wait", 64'(mem_req), 64'd0);
        next_cycle();
        rst    = 1'b0;
        acs_en = 1'b0;
        #1;
        chk("rw_req_after_rst", 64'(mem_req), 64'd0);
        next_cycle();
        next_cycle();
        mem_rvalid = 1'b1;
        next_cycle();
        mem_rvalid = 1'b0;
        #1;
        chk("rw_rdata_stale", acs_rdata, 64'd0);
        chk("rw_req_stale",   64'(mem_req), 64'd0);
        next_cycle();
        txn(1'b0, 8'hFF, 64'h0000_3000, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1, 1'b0);
        chk("rw_post_first_req", 64'(r_first_req), 64'd1);
        chk("rw_post_stall",     64'(r_stall),     64'd3);
        chk("rw_post_rdata",     r_rd,             64'h0F0F_0F0F_0F0F_0F0F);

        // Back-to-back loads: second request seen in the cycle after DONE
        txn(1'b0, 8'hFF, 64'h0000_4000, 64'h0, 64'hA1A2_A3A4_A5A6_A7A8, 0, 1, 1'b1);
        chk("b2b_first_rdata", r_rd, 64'hA1A2_A3A4_A5A6_A7A8);
        txn(1'b0, 8'h0F, 64'h0000_4008, 64'h0, 64'h0000_0000_1234_5678, 0, 1, 1'b0);
        chk("b2b_second_req_cyc", 64'(r_first_req), 64'd1);
        chk("b2b_second_addr",    r_addr,           64'h0000_4008);
        chk("b2b_second_stall",   64'(r_stall),     64'd3);
        chk("b2b_second_rdata",   r_rd,             64'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute stage in the single-cycle core. It takes the execute stage's memory access request (enable, write flag, byte-size mask, address, store data), runs it as a multi-cycle transaction on a doubleword-wide memory bus, and holds the core with `stall` until the access completes. It then returns read data right-justified to bit 0; execute applies sign or zero extension.

## Interface
Parameters:
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width; the bus is one doubleword.

Ports:
- `clk`  in  1: core clock; single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `acs_en`  in  1: access request from execute, combinational, held stable while `stall`=1.
- `acs_wr`  in  1: 1=store, 0=load.
- `acs_bytes`  in  8: size mask; only 0x01, 0x03, 0x0F or 0xFF.
- `acs_addr`  in  64: byte address.
- `acs_wdata`  in  64: store data, right-justified.
- `acs_rdata`  out  64: load data, right-justified; valid in DONE.
- `stall`  out  1: freeze PC and register-file write.
- `misalign`  out  1: misaligned-access pulse; tied 0 when `LSU_MISALIGN_CHK_EN` is undefined.
- `mem_req`  out  1: bus request.
- `mem_we`  out  1: bus write.
- `mem_addr`  out  64: doubleword-aligned address, `{acs_addr[63:3],3'b0}`.
- `mem_wstrb`  out  8: byte write strobes.
- `mem_wdata`  out  64: lane-shifted store data.
- `mem_gnt`  in  1: request accepted.
- `mem_rvalid`  in  1: response (read data or write ack); asserted no earlier than the cycle after `mem_gnt`.
- `mem_rdata`  in  64: read doubleword.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - With `acs_en`=1, register we, addr, strobes and data, then go to REQ.
  - With `acs_en`=0, stay in IDLE.
- REQ:
  - `mem_req`=1 with registered fields.
  - `mem_gnt`=1 → WAIT. Otherwise stay, with all bus fields held stable.
- WAIT:
  - `mem_req`=0.
  - `mem_rvalid`=1 → capture `mem_rdata >> (8*addr[2:0])` masked by size into `acs_rdata`, then go to DONE.
  - Stores ignore `mem_rdata`; `acs_rdata` is 0 for stores.
- DONE: `stall`=0 for exactly one cycle while the core retires the instruction, then unconditionally go to IDLE. This prevents re-issuing the same request.
- `stall` = `acs_en` & (state != DONE). Non-memory instructions never stall.
- Lane mapping:
  - `mem_wstrb` = (`acs_bytes` << `acs_addr[2:0]`)[7:0].
  - `mem_wdata` = `acs_wdata` << (8*`acs_addr[2:0]`).
- Accesses crossing a doubleword boundary, without the check: strobe bits above lane 7 are dropped; read lanes beyond byte 7 return 0.
- `mem_rvalid` outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `mem_wstrb`, `misalign` = 0; `mem_addr`, `mem_wdata`, `acs_rdata` = 0.
- Minimum latency with `mem_gnt` in REQ and `mem_rvalid` one cycle later:
  - Cycle 0 IDLE (request seen).
  - Cycle 1 REQ.
  - Cycle 2 WAIT.
  - Cycle 3 DONE (retire).
  - `stall` is high for cycles 0–2.
- Each extra gnt or rvalid wait cycle adds one stall cycle. There is no timeout.
- Back-to-back memory instructions: the second request is seen in the cycle after DONE, so there is at least one IDLE cycle between transactions.
- `rst` in REQ or WAIT: return to IDLE next cycle and drop `mem_req`. A later stale `mem_rvalid` is ignored.
- `rst` outranks every transition.

## Configuration
- Macro `LSU_MISALIGN_CHK_EN`.
- Defined: in IDLE, `acs_en` with `acs_addr` not a multiple of the access size skips the bus and goes IDLE→DONE. `misalign`=1 in DONE only; `acs_rdata`=0; no store side effect. `stall` is high for one cycle.
- Undefined: no check; truncation behaviour as in Operation; `misalign` is constant 0.

## Structure
- `lsu_pkg`:
  - State enum (IDLE/REQ/WAIT/DONE).
  - Size-mask constants `SZ_B`=8'h01, `SZ_H`=8'h03, `SZ_W`=8'h0F, `SZ_D`=8'hFF.
  - Function mapping a size mask to alignment mask (0, 1, 3, 7).
- Sub-module `lsu_align`: combinational lane shifter (write-data/strobe shift left, read-data shift right plus size mask). Instantiated once. The FSM and registers live in `lsu`.

## Test plan
- Load double, aligned: `acs_bytes`=0xFF, `acs_addr`=0x8000_0008; memory returns 0x1122334455667788 one cycle after gnt → `mem_addr`=0x8000_0008, `stall` high 3 cycles, `acs_rdata`=0x1122334455667788 in DONE.
- Store byte, lane 5: `acs_addr`=0x8000_0005, `acs_wdata`=0xAB → `mem_wstrb`=0x20, `mem_wdata`=0x0000_AB00_0000_0000, `mem_we`=1, `mem_addr`=0x8000_0000.
- Load half, lane 6, with gnt delay: `mem_gnt` delayed 3 cycles, `mem_rdata`=0xBEEF_0000_0000_0000 → `mem_req` held 4 cycles with stable fields, `acs_rdata`=0xBEEF, `stall` high 6 cycles.
- Reset mid-WAIT: `rst`=1 during WAIT, then `mem_rvalid`=1 two cycles later → state IDLE, `mem_req`=0, `acs_rdata` stays 0, no DONE cycle.
- Misaligned word, macro defined: `acs_bytes`=0x0F, `acs_addr`=0x8000_0006 → no `mem_req`, `misalign`=1 for one cycle, `stall` high 1 cycle.
- Misaligned word, macro undefined: same access → `mem_wstrb`=0xC0, 4-cycle stall.
- Two back-to-back loads: second `mem_req` rises exactly 2 cycles after the first DONE cycle.
